serial_operand_serializer: RTL and testbench

SERIAL_OPERAND_SERIALIZER -- requirements
Module: serial_operand_serializer

---
 rtl/serial_pkg.sv | 13 +
 rtl/sync_fifo2.sv | 53 +++++
 rtl/serial_operand_serializer.sv | 117 +++++++++++
 tb/tb_serial_operand_serializer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and defaults for the serial operand serializer
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_GAP   = 1;

endpackage

// File: rtl/sync_fifo2.sv
// rtl/sync_fifo2.sv - two-entry operand buffer with wrapping pointers and separate count
module sync_fifo2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // The count disambiguates full from empty since both pointers are one bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/serial_operand_serializer.sv
// rtl/serial_operand_serializer.sv - buffers parallel operands and shifts them out LSB first with idle gaps
module serial_operand_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             tx_start,
    output logic             ser_out,
    output logic             frame_done,
    output logic             busy
);

    localparam int              BCW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [2:0]      LAST_GAP = 3'(GAP - 1);

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [BCW-1:0]   r_bitcnt;
    logic [BCW-1:0]   w_bitcnt_nxt;
    logic [2:0]       r_gapcnt;
    logic [2:0]       w_gapcnt_nxt;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_head;

    sync_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (s_valid),
        .i_data  (s_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign s_ready = !w_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_gapcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_gapcnt <= w_gapcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_bitcnt_nxt = r_bitcnt;
        w_gapcnt_nxt = r_gapcnt;
        w_pop        = 1'b0;
        tx_start     = 1'b0;
        ser_out      = 1'b0;
        frame_done   = 1'b0;
        busy         = (r_state != ST_IDLE) || !w_empty;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shreg_nxt  = w_head;
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_out      = r_shreg[0];
                tx_start     = (r_bitcnt == '0);
                frame_done   = (r_bitcnt == LAST_BIT);
                w_shreg_nxt  = r_shreg >> 1;
                w_bitcnt_nxt = r_bitcnt + 1'b1;
                if (r_bitcnt == LAST_BIT) begin
                    w_bitcnt_nxt = '0;
                    w_gapcnt_nxt = '0;
                    w_state_nxt  = ST_GAP;
                end
            end
            ST_GAP: begin
                // Chaining the next pop here keeps frames exactly WIDTH+GAP apart.
                if (r_gapcnt == LAST_GAP) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shreg_nxt  = w_head;
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = ST_SHIFT;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                    end
                end else begin
                    w_gapcnt_nxt = r_gapcnt + 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// tb/tb_serial_operand_serializer.sv - randomized self-checking bench with a timeline reference model
module tb_serial_operand_serializer;

    localparam int W  = 4;
    localparam int G  = 1;
    localparam int W2 = 8;
    localparam int G2 = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          tx_start, ser_out, frame_done, busy;
    logic          s_valid2 = 1'b0;
    logic          s_ready2;
    logic [W2-1:0] s_data2 = '0;
    logic          tx_start2, ser_out2, frame_done2, busy2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Timeline model: each accepted operand has a push edge and a frame start cycle.
    int           pe [512];
    int           st [512];
    logic [W-1:0] od [512];
    int           nops = 0;
    int           live = 0;
    int           last_start = -100;
    logic         obs_tx, obs_ser;

    always #5 clk = ~clk;

    serial_operand_serializer #(.WIDTH(W), .GAP(G)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .tx_start(tx_start), .ser_out(ser_out), .frame_done(frame_done), .busy(busy)
    );

    serial_operand_serializer #(.WIDTH(W2), .GAP(G2)) dut8 (
        .clk(clk), .reset(reset), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .tx_start(tx_start2), .ser_out(ser_out2), .frame_done(frame_done2), .busy(busy2)
    );

    function automatic int occ(int n);
        int c = 0;
        for (int i = live; i < nops; i++) if (pe[i] <= n && n < st[i]) c++;
        return c;
    endfunction

    function automatic logic exp_ser(int n);
        logic [W-1:0] v;
        for (int i = live; i < nops; i++) begin
            if (n >= st[i] && n < st[i] + W) begin
                v = od[i];
                return v[n - st[i]];
            end
        end
        return 1'b0;
    endfunction

    function automatic logic exp_tx(int n);
        for (int i = live; i < nops; i++) if (n == st[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_fd(int n);
        for (int i = live; i < nops; i++) if (n == st[i] + W - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_busy(int n);
        if (occ(n) > 0) return 1'b1;
        for (int i = live; i < nops; i++) if (n >= st[i] && n < st[i] + W + G) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic v, input logic [W-1:0] d);
        logic er;
        s_valid = v;
        s_data  = d;
        @(negedge clk);
        er = (occ(cyc) < 2);
        checks += 5;
        if (s_ready !== er) begin errors++; $display("FAIL s_ready cyc=%0d got=%b exp=%b", cyc, s_ready, er); end
        if (tx_start !== exp_tx(cyc)) begin errors++; $display("FAIL tx_start cyc=%0d got=%b exp=%b", cyc, tx_start, exp_tx(cyc)); end
        if (ser_out !== exp_ser(cyc)) begin errors++; $display("FAIL ser_out cyc=%0d got=%b exp=%b", cyc, ser_out, exp_ser(cyc)); end
        if (frame_done !== exp_fd(cyc)) begin errors++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd(cyc)); end
        if (busy !== exp_busy(cyc)) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy(cyc)); end
        obs_tx  = tx_start;
        obs_ser = ser_out;
        if (v && er) begin
            pe[nops] = cyc + 1;
            st[nops] = (cyc + 2 > last_start + W + G) ? cyc + 2 : last_start + W + G;
            od[nops] = d;
            last_start = st[nops];
            nops++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({tx_start, ser_out, frame_done, busy, s_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL %s got=%b exp=00001", name, {tx_start, ser_out, frame_done, busy, s_ready});
        end
    endtask

    task automatic test_reset();
        #1;
        check_all_zero("reset_outputs");
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc = 0;
        step(1'b0, '0);
    endtask

    task automatic test_single();
        step(1'b1, 4'b1011);
        for (int i = 0; i < 8; i++) step(1'b0, '0);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 4'h3);
        step(1'b1, 4'hA);
        step(1'b1, 4'hF);
        for (int i = 0; i < 16; i++) step(1'b0, '0);
    endtask

    task automatic test_full();
        step(1'b1, 4'h6);
        step(1'b1, 4'h9);
        step(1'b1, 4'hC);
        for (int i = 0; i < 3; i++) step(1'b1, 4'h5);
        for (int i = 0; i < 18; i++) step(1'b0, '0);
    endtask

    task automatic test_mid_reset();
        int target;
        step(1'b1, 4'hC);
        target = st[nops-1] + 2;
        for (int i = 0; i < 10 && cyc < target; i++) step(1'b0, '0);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset_outputs");
        @(posedge clk);
        #1;
        reset = 1'b1;
        live = nops;
        last_start = -100;
        cyc++;
        for (int i = 0; i < 8; i++) step(1'b0, '0);
        step(1'b1, 4'h9);
        for (int i = 0; i < 7; i++) step(1'b0, '0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) step(($urandom % 3) == 0, W'($urandom));
        for (int i = 0; i < 15; i++) step(1'b0, '0);
    endtask

    task automatic test_adder();
        logic [W-1:0] ops [3];
        logic [W-1:0] sum;
        logic         carry;
        int           k, nres;
        logic         active;
        ops[0] = 4'h0; ops[1] = 4'h7; ops[2] = 4'hF;
        active = 1'b0; k = 0; nres = 0; carry = 1'b0; sum = '0;
        for (int i = 0; i < 24; i++) begin
            step(i < 3, (i < 3) ? ops[i] : 4'h0);
            if (obs_tx) begin active = 1'b1; carry = 1'b1; k = 0; sum = '0; end
            if (active && k < W) begin
                sum[k] = obs_ser ^ carry;
                carry  = obs_ser & carry;
                k++;
            end else if (active) begin
                active = 1'b0;
                if (nres < 3) begin
                    checks += 2;
                    if (sum !== ops[nres] + 4'd1) begin errors++; $display("FAIL adder_sum op=%h got=%h exp=%h", ops[nres], sum, ops[nres] + 4'd1); end
                    if (carry !== (ops[nres] == 4'hF)) begin errors++; $display("FAIL adder_cout op=%h got=%b exp=%b", ops[nres], carry, ops[nres] == 4'hF); end
                end
                nres++;
            end
        end
        checks++;
        if (nres != 3) begin errors++; $display("FAIL adder_frames got=%0d exp=3", nres); end
    endtask

    task automatic test_gap3();
        int           t_start [$];
        logic [W2-1:0] fr;
        int           k;
        logic         col;
        int           nfr;
        col = 1'b0; k = 0; nfr = 0; fr = '0;
        for (int i = 0; i < 36; i++) begin
            s_valid2 = (i < 2);
            s_data2  = 8'h81;
            @(negedge clk);
            if (tx_start2) begin t_start.push_back(i); col = 1'b1; k = 0; fr = '0; end
            if (col) begin
                fr[k] = ser_out2;
                k++;
                if (k == W2) begin
                    col = 1'b0;
                    nfr++;
                    checks++;
                    if (fr !== 8'h81) begin errors++; $display("FAIL gap3_bits got=%h exp=81", fr); end
                end
            end
            @(posedge clk);
            #1;
        end
        s_valid2 = 1'b0;
        checks += 2;
        if (t_start.size() != 2 || nfr != 2) begin
            errors++;
            $display("FAIL gap3_frames got=%0d exp=2", t_start.size());
        end else if (t_start[1] - t_start[0] != W2 + G2) begin
            errors++;
            $display("FAIL gap3_spacing got=%0d exp=%0d", t_start[1] - t_start[0], W2 + G2);
        end
        if (busy2 !== 1'b0) begin errors++; $display("FAIL gap3_busy got=%b exp=0", busy2); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_mid_reset();
        test_random();
        test_adder();
        test_gap3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
